// File: rtl/debounce_pkg.sv
// Shared types, defaults and counter sizing for the push-button debounce bank.
package debounce_pkg;

  localparam int unsigned DefNCh           = 4;
  localparam int unsigned DefActiveLow     = 1;
  localparam int unsigned DefDebounceCycles = 65536;
  localparam int unsigned DefHoldCycles    = 25_000_000;
  localparam int unsigned DefRepeatCycles  = 5_000_000;

  typedef struct packed {
    logic state;
    logic down;
    logic up;
    logic hold;
    logic rep;
  } chan_evt_t;

  typedef enum logic {
    PhHold,
    PhRepeat
  } hold_phase_e;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input longint unsigned n);
    if (n <= 64'd2) begin
      return 1;
    end
    return int'($clog2(n));
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One button channel: polarity normalise, 2-FF synchroniser, debounce counter,
// and hold/auto-repeat timing with single-cycle registered event pulses.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int unsigned ACTIVE_LOW      = DefActiveLow,
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned HOLD_CYCLES     = DefHoldCycles,
  parameter int unsigned REPEAT_CYCLES   = DefRepeatCycles
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      btn_i,
  output chan_evt_t evt_o
);

  localparam int unsigned DbW     = cnt_width(longint'(DEBOUNCE_CYCLES));
  localparam int unsigned HoldMax = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HoldW   = cnt_width(longint'(HoldMax) + 64'd1);
  localparam bit          RepEn   = (REPEAT_CYCLES != 0);

  localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
  localparam logic [HoldW-1:0] RepLast  = RepEn ? HoldW'(REPEAT_CYCLES - 1) : '0;

  logic raw_n;
  logic sync0_d, sync0_q;
  logic sync1_d, sync1_q;
  logic state_d, state_q;
  logic down_d, down_q;
  logic up_d, up_q;
  logic hold_d, hold_q;
  logic rep_d, rep_q;
  logic [DbW-1:0]   db_cnt_d, db_cnt_q;
  logic [HoldW-1:0] hold_cnt_d, hold_cnt_q;
  hold_phase_e      phase_d, phase_q;

  assign raw_n   = (ACTIVE_LOW != 0) ? ~btn_i : btn_i;
  assign sync0_d = raw_n;
  assign sync1_d = sync0_q;

  // Debounce: any agreeing cycle clears the count; the final disagreeing cycle flips state.
  always_comb begin
    state_d  = state_q;
    db_cnt_d = '0;
    if (sync1_q != state_q) begin
      if (db_cnt_q == DbLast) begin
        state_d = ~state_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign down_d = state_d & ~state_q;
  assign up_d   = ~state_d & state_q;

  // Gate on both current and next state so the release edge never emits hold/repeat.
  always_comb begin
    phase_d    = phase_q;
    hold_cnt_d = hold_cnt_q;
    hold_d     = 1'b0;
    rep_d      = 1'b0;
    if (!(state_q && state_d)) begin
      phase_d    = PhHold;
      hold_cnt_d = '0;
    end else begin
      unique case (phase_q)
        PhHold: begin
          if (hold_cnt_q == HoldLast) begin
            hold_d     = 1'b1;
            hold_cnt_d = '0;
            phase_d    = PhRepeat;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        PhRepeat: begin
          if (RepEn) begin
            if (hold_cnt_q == RepLast) begin
              rep_d      = 1'b1;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0_q    <= 1'b0;
      sync1_q    <= 1'b0;
      state_q    <= 1'b0;
      down_q     <= 1'b0;
      up_q       <= 1'b0;
      hold_q     <= 1'b0;
      rep_q      <= 1'b0;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      phase_q    <= PhHold;
    end else begin
      sync0_q    <= sync0_d;
      sync1_q    <= sync1_d;
      state_q    <= state_d;
      down_q     <= down_d;
      up_q       <= up_d;
      hold_q     <= hold_d;
      rep_q      <= rep_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      phase_q    <= phase_d;
    end
  end

  assign evt_o.state = state_q;
  assign evt_o.down  = down_q;
  assign evt_o.up    = up_q;
  assign evt_o.hold  = hold_q;
  assign evt_o.rep   = rep_q;

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent push-button conditioners; one debounce_chan per input bit.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH            = DefNCh,
  parameter int unsigned ACTIVE_LOW      = DefActiveLow,
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned HOLD_CYCLES     = DefHoldCycles,
  parameter int unsigned REPEAT_CYCLES   = DefRepeatCycles
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_i,
  output logic [N_CH-1:0] state_o,
  output logic [N_CH-1:0] down_o,
  output logic [N_CH-1:0] up_o,
  output logic [N_CH-1:0] hold_o,
  output logic [N_CH-1:0] repeat_o
);

  chan_evt_t evt [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    debounce_chan #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .btn_i (btn_i[i]),
      .evt_o (evt[i])
    );

    assign state_o[i]  = evt[i].state;
    assign down_o[i]   = evt[i].down;
    assign up_o[i]     = evt[i].up;
    assign hold_o[i]   = evt[i].hold;
    assign repeat_o[i] = evt[i].rep;
  end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel push-button conditioner: per channel it synchronises a glitchy asynchronous input, debounces it with a programmable stability window, and produces a level plus single-cycle press, release, long-press and auto-repeat events. It sits between board push-buttons and the control FSMs, replacing single-channel debouncers with one configurable instance per button group.

## Interface
- N_CH, default 4: number of independent channels, 1..32.
- ACTIVE_LOW, default 1: 1 = raw input pressed when 0; 0 = pressed when 1.
- DEBOUNCE_CYCLES, default 65536: consecutive cycles of disagreement required to accept a new level, 2..2^24.
- HOLD_CYCLES, default 25_000_000: cycles pressed before the long-press event, ≥ 2.
- REPEAT_CYCLES, default 5_000_000: auto-repeat period after long-press; 0 disables auto-repeat.
- clk  in  1  system clock, only clock.
- rst  in  1  asynchronous, active-high reset.
- btn_i  in  N_CH  raw asynchronous button inputs.
- state_o  out  N_CH  debounced level, 1 = pressed.
- down_o  out  N_CH  1-cycle pulse when state_o rises.
- up_o  out  N_CH  1-cycle pulse when state_o falls.
- hold_o  out  N_CH  1-cycle pulse when a press has lasted HOLD_CYCLES.
- repeat_o  out  N_CH  1-cycle pulse every REPEAT_CYCLES after hold_o while still pressed.

## Operation
- Per channel: polarity normalise (invert when ACTIVE_LOW), 2-FF synchroniser sync0→sync1.
- Debounce counter, width $clog2(DEBOUNCE_CYCLES): cleared when sync1 == state; else incremented. On the edge where counter == DEBOUNCE_CYCLES-1 and sync1 != state: state toggles, counter clears.
- Any single cycle of agreement clears the counter; glitches shorter than DEBOUNCE_CYCLES never change state.
- down_o/up_o are registered: asserted exactly in the first cycle state_o shows the new value, deasserted the next cycle.
- Hold counter, width $clog2(max(HOLD_CYCLES,REPEAT_CYCLES)+1): cleared while state == 0; counts while state == 1. hold_o fires on the edge where count reaches HOLD_CYCLES-1, i.e. high in the HOLD_CYCLES-th cycle after down_o (down_o cycle = cycle 0). Counter then reloads to 0 in repeat phase.
- Repeat phase (REPEAT_CYCLES > 0): repeat_o pulses every REPEAT_CYCLES cycles after hold_o until release. REPEAT_CYCLES = 0: counter saturates after hold_o, repeat_o stays 0.
- Release (up_o) clears hold/repeat state the same edge; no hold_o/repeat_o in or after the up_o cycle.
- Channels fully independent; simultaneous events on different channels each produce their own pulses.

## Timing
- Reset (asynchronous assert, released synchronously by the system): sync0, sync1, state_o, all counters and all pulse outputs = 0. Released-level resets mean no spurious down_o after reset even if a button is held; a held button yields down_o DEBOUNCE_CYCLES+2 cycles after reset release.
- Press latency: counting the first edge that samples the new raw level as edge 1, state_o and down_o change after edge DEBOUNCE_CYCLES+2. Same for release/up_o.
- Reset mid-operation: all partial counts lost; pulses never emitted from pre-reset history.
- Counters never wrap; comparisons are exact equalities.

## Structure
- Package debounce_pkg: counter-width helper function, default-parameter localparams, channel-event struct (state, down, up, hold, rep).
- Sub-module debounce_chan: one channel (sync, debounce counter, hold/repeat counter); debounce_bank is a generate loop of N_CH instances plus output packing.

## Test plan
- Clean press, N_CH=2, ACTIVE_LOW=1, DEBOUNCE_CYCLES=4: btn_i[0] 1→0 sampled at edge 1 -> state_o[0]=1 and down_o[0]=1 after edge 6, down_o low after edge 7; channel 1 silent.
- Bounce: DEBOUNCE_CYCLES=4, input toggles with 3-cycle pulses for 30 cycles then settles low -> no pulses during bounce, exactly one down_o 6 edges after final settle.
- Hold/repeat: DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, hold 30 cycles -> hold_o 10 cycles after down_o, repeat_o at +13,+16,+19…, none after up_o.
- REPEAT_CYCLES=0: same press -> single hold_o, repeat_o never asserts.
- Reset while held: rst pulse mid-press -> all outputs 0 immediately; down_o recurs 6 cycles after release of rst (DEBOUNCE_CYCLES=4).
- Simultaneous: both channels pressed on the same edge, ACTIVE_LOW=0 -> down_o=2'b11 in the same cycle; release channel 1 only -> up_o=2'b10 only.
